// File: rtl/ysyx_csr_file.sv
// ysyx_csr_file: machine-mode CSR file for the EXU.
// Holds trap state, interrupt enable/pending, scratch and 64-bit counters.
// Performs Zicsr read-modify-write, trap entry and mret in one cycle.
// Drives the redirect target, mepc and the interrupt request to fetch.
module ysyx_csr_file #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MTVEC_RST = '0,
  parameter logic [31:0]     VENDOR_ID = 32'h79737978,
  parameter logic [31:0]     ARCH_ID   = 32'h015fde77,
  parameter int              HAS_CNT   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_valid,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret_valid,
  input  logic            retire,
  input  logic            irq_mtip,
  input  logic            irq_meip,
  output logic [XLEN-1:0] trap_target_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            irq_req_o,
  output logic [XLEN-1:0] irq_cause_o
);

  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  // Architectural state
  logic            mie_st_q, mie_st_d;   // mstatus.MIE
  logic            mpie_q, mpie_d;       // mstatus.MPIE
  logic [XLEN-1:0] mie_q, mie_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mscratch_q, mscratch_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [63:0]     mcycle_q, mcycle_d;
  logic [63:0]     minstret_q, minstret_d;

  // Two-flop synchronisers for the asynchronous interrupt lines
  logic mtip_s1_q, mtip_s2_q, meip_s1_q, meip_s2_q;

  // Combinational helpers
  logic [XLEN-1:0] mstatus_s, mip_s, misa_s, rdata_s, wval_s, pend_s, base_s;
  logic            addr_ok_s, ro_s, wr_try_s, wen_s;

  // Assemble the read views of composite registers
  always_comb begin
    mstatus_s        = '0;
    mstatus_s[12:11] = 2'b11;
    mstatus_s[7]     = mpie_q;
    mstatus_s[3]     = mie_st_q;
    mip_s            = '0;
    mip_s[7]         = mtip_s2_q;
    mip_s[11]        = meip_s2_q;
    misa_s           = '0;
    misa_s[XLEN-1:XLEN-2] = (XLEN == 64) ? 2'b10 : 2'b01;
    misa_s[8]        = 1'b1;
  end

  // Address decode: old value, existence and read-only attribute
  always_comb begin
    rdata_s   = '0;
    addr_ok_s = 1'b1;
    ro_s      = 1'b0;
    case (csr_addr)
      12'h300: rdata_s = mstatus_s;
      12'h301: begin rdata_s = misa_s; ro_s = 1'b1; end
      12'h304: rdata_s = mie_q;
      12'h305: rdata_s = mtvec_q;
      12'h340: rdata_s = mscratch_q;
      12'h341: rdata_s = mepc_q;
      12'h342: rdata_s = mcause_q;
      12'h343: rdata_s = mtval_q;
      12'h344: begin rdata_s = mip_s; ro_s = 1'b1; end
      12'hB00: rdata_s = mcycle_q[XLEN-1:0];
      12'hB02: rdata_s = minstret_q[XLEN-1:0];
      12'hB80: begin
        if (XLEN == 32) rdata_s = XLEN'(mcycle_q[63:32]);
        else            addr_ok_s = 1'b0;
      end
      12'hB82: begin
        if (XLEN == 32) rdata_s = XLEN'(minstret_q[63:32]);
        else            addr_ok_s = 1'b0;
      end
      12'hF11: begin rdata_s = XLEN'(VENDOR_ID); ro_s = 1'b1; end
      12'hF12: begin rdata_s = XLEN'(ARCH_ID);   ro_s = 1'b1; end
      12'hF13: ro_s = 1'b1;
      12'hF14: ro_s = 1'b1;
      default: addr_ok_s = 1'b0;
    endcase
  end

  // Write intent, legality and the read-modify-write value
  always_comb begin
    // RS/RC with a zero operand is a pure read and never writes
    wr_try_s    = (csr_op == OP_RW) ||
                  ((csr_op != OP_RD) && (csr_wdata != '0));
    csr_illegal = !addr_ok_s || (ro_s && wr_try_s);
    wen_s       = csr_valid && !csr_illegal && wr_try_s;
    csr_rdata   = rdata_s;
    case (csr_op)
      OP_RW:   wval_s = csr_wdata;
      OP_RS:   wval_s = rdata_s | csr_wdata;
      OP_RC:   wval_s = rdata_s & ~csr_wdata;
      default: wval_s = rdata_s;
    endcase
  end

  // Next state: CSR write first, then mret, then trap, so later wins per field
  always_comb begin
    mie_st_d   = mie_st_q;
    mpie_d     = mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mtval_d    = mtval_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = retire ? (minstret_q + 64'd1) : minstret_q;
    if (wen_s) begin
      case (csr_addr)
        12'h300: begin mie_st_d = wval_s[3]; mpie_d = wval_s[7]; end
        12'h304: begin
          mie_d     = '0;
          mie_d[7]  = wval_s[7];
          mie_d[11] = wval_s[11];
        end
        12'h305: begin mtvec_d = wval_s; mtvec_d[1] = 1'b0; end
        12'h340: mscratch_d = wval_s;
        12'h341: mepc_d = {wval_s[XLEN-1:2], 2'b00};
        12'h342: mcause_d = wval_s;
        12'h343: mtval_d = wval_s;
        // A counter write replaces the increment; the other half holds
        12'hB00: begin mcycle_d = mcycle_q; mcycle_d[XLEN-1:0] = wval_s; end
        12'hB02: begin minstret_d = minstret_q; minstret_d[XLEN-1:0] = wval_s; end
        12'hB80: begin mcycle_d = mcycle_q; mcycle_d[63:32] = wval_s[31:0]; end
        12'hB82: begin minstret_d = minstret_q; minstret_d[63:32] = wval_s[31:0]; end
        default: begin end
      endcase
    end else begin
    end
    if (mret_valid) begin
      mie_st_d = mpie_q;
      mpie_d   = 1'b1;
    end else begin
    end
    if (trap_valid) begin
      mpie_d   = mie_st_q;
      mie_st_d = 1'b0;
      mepc_d   = {trap_pc[XLEN-1:2], 2'b00};
      mcause_d = trap_cause;
      mtval_d  = trap_tval;
    end else begin
    end
    if (HAS_CNT == 0) begin
      mcycle_d   = 64'd0;
      minstret_d = 64'd0;
    end else begin
    end
  end

  // CSR state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mie_st_q   <= 1'b0;
      mpie_q     <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= {MTVEC_RST[XLEN-1:2], 1'b0, MTVEC_RST[0]};
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mie_st_q   <= mie_st_d;
      mpie_q     <= mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mtval_q    <= mtval_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  // Synchronise the interrupt lines into the clock domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtip_s1_q <= 1'b0;
      mtip_s2_q <= 1'b0;
      meip_s1_q <= 1'b0;
      meip_s2_q <= 1'b0;
    end else begin
      mtip_s1_q <= irq_mtip;
      mtip_s2_q <= mtip_s1_q;
      meip_s1_q <= irq_meip;
      meip_s2_q <= meip_s1_q;
    end
  end

  // Redirect target, mepc and the prioritised interrupt request
  always_comb begin
    base_s = {mtvec_q[XLEN-1:2], 2'b00};
    if (mtvec_q[0] && trap_cause[XLEN-1]) begin
      trap_target_o = base_s + {trap_cause[XLEN-3:0], 2'b00};
    end else begin
      trap_target_o = base_s;
    end
    mepc_o      = mepc_q;
    pend_s      = mip_s & mie_q;
    irq_req_o   = mie_st_q && (pend_s != '0);
    irq_cause_o = '0;
    if (irq_req_o) begin
      irq_cause_o[XLEN-1] = 1'b1;
      irq_cause_o[3:0]    = pend_s[11] ? 4'd11 : 4'd7;
    end else begin
    end
  end

endmodule

// File: tb/tb_ysyx_csr_file.sv
// Directed testbench for ysyx_csr_file (XLEN=32, MTVEC_RST=0x80000000).
module tb_ysyx_csr_file;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        csr_valid = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [11:0] csr_addr = 12'h000;
  logic [31:0] csr_wdata = 32'h0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_cause = 32'h0;
  logic [31:0] trap_pc = 32'h0;
  logic [31:0] trap_tval = 32'h0;
  logic        mret_valid = 1'b0;
  logic        retire = 1'b0;
  logic        irq_mtip = 1'b0;
  logic        irq_meip = 1'b0;
  logic [31:0] trap_target_o;
  logic [31:0] mepc_o;
  logic        irq_req_o;
  logic [31:0] irq_cause_o;

  int n_checks = 0;
  int n_errs   = 0;
  logic [31:0] rv;
  logic        ill;

  ysyx_csr_file #(
    .XLEN(32), .MTVEC_RST(32'h80000000),
    .VENDOR_ID(32'h79737978), .ARCH_ID(32'h015fde77), .HAS_CNT(1)
  ) dut (
    .clk(clk), .rst(rst),
    .csr_valid(csr_valid), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .trap_tval(trap_tval), .mret_valid(mret_valid), .retire(retire),
    .irq_mtip(irq_mtip), .irq_meip(irq_meip),
    .trap_target_o(trap_target_o), .mepc_o(mepc_o),
    .irq_req_o(irq_req_o), .irq_cause_o(irq_cause_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Combinational read without waiting for a clock phase
  task automatic peek(input logic [11:0] a, output logic [31:0] d, output logic il);
    csr_valid = 1'b0;
    csr_op    = 2'b00;
    csr_addr  = a;
    #1;
    d  = csr_rdata;
    il = csr_illegal;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    logic il;
    @(negedge clk);
    peek(a, d, il);
  endtask

  // One committed CSR instruction; illegal flag sampled before the edge
  task automatic csr_wr(input logic [1:0] op, input logic [11:0] a,
                        input logic [31:0] wd, output logic il);
    @(negedge clk);
    csr_valid = 1'b1;
    csr_op    = op;
    csr_addr  = a;
    csr_wdata = wd;
    #1;
    il = csr_illegal;
    @(posedge clk);
    #1;
    csr_valid = 1'b0;
    csr_op    = 2'b00;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Reset state
    rd(12'h305, rv); check_eq("rst_mtvec", rv, 32'h80000000);
    rd(12'h300, rv); check_eq("rst_mstatus", rv, 32'h00001800);
    rd(12'hF11, rv); check_eq("rst_vendor", rv, 32'h79737978);
    rd(12'h340, rv); check_eq("rst_mscratch", rv, 32'h0);
    check_eq("rst_target", trap_target_o, 32'h80000000);
    check_eq("rst_mepc_o", mepc_o, 32'h0);
    check_eq("rst_irq_req", {31'd0, irq_req_o}, 32'h0);
    check_eq("rst_irq_cause", irq_cause_o, 32'h0);

    // Read-modify-write
    csr_wr(2'b01, 12'h340, 32'hA5A5A5A5, ill);
    csr_wr(2'b10, 12'h340, 32'h0000000F, ill);
    csr_wr(2'b11, 12'h340, 32'h000000A0, ill);
    rd(12'h340, rv); check_eq("rmw_mscratch", rv, 32'hA5A5A50F);
    csr_wr(2'b10, 12'hF11, 32'h0, ill);
    check_eq("rs0_ro_legal", {31'd0, ill}, 32'h0);
    rd(12'hF11, rv); check_eq("rs0_ro_value", rv, 32'h79737978);

    // Illegal accesses
    csr_wr(2'b01, 12'hF12, 32'h1, ill);
    check_eq("ill_wr_archid", {31'd0, ill}, 32'h1);
    rd(12'hF12, rv); check_eq("ill_archid_kept", rv, 32'h015fde77);
    @(negedge clk);
    peek(12'h7C0, rv, ill);
    check_eq("ill_unimpl", {31'd0, ill}, 32'h1);
    csr_wr(2'b01, 12'h344, 32'hFFFFFFFF, ill);
    check_eq("ill_wr_mip", {31'd0, ill}, 32'h1);
    @(negedge clk);
    peek(12'hB80, rv, ill);
    check_eq("mcycleh_legal32", {31'd0, ill}, 32'h0);

    // Write masks
    csr_wr(2'b01, 12'h341, 32'h12345677, ill);
    rd(12'h341, rv); check_eq("mepc_mask", rv, 32'h12345674);
    csr_wr(2'b01, 12'h305, 32'hFFFFFFFF, ill);
    rd(12'h305, rv); check_eq("mtvec_mask", rv, 32'hFFFFFFFD);
    csr_wr(2'b01, 12'h304, 32'hFFFFFFFF, ill);
    rd(12'h304, rv); check_eq("mie_mask", rv, 32'h00000880);
    csr_wr(2'b01, 12'h304, 32'h0, ill);

    // Trap entry with vectored mtvec
    csr_wr(2'b01, 12'h300, 32'h8, ill);
    csr_wr(2'b01, 12'h305, 32'h101, ill);
    @(negedge clk);
    trap_valid = 1'b1;
    trap_cause = 32'h80000007;
    trap_pc    = 32'h1002;
    trap_tval  = 32'hDEAD;
    #1;
    check_eq("trap_target_vec", trap_target_o, 32'h11C);
    @(posedge clk);
    #1;
    trap_valid = 1'b0;
    check_eq("trap_mepc_o", mepc_o, 32'h1000);
    check_eq("trap_target_after", trap_target_o, 32'h11C);
    rd(12'h300, rv); check_eq("trap_mstatus", rv, 32'h00001880);
    rd(12'h342, rv); check_eq("trap_mcause", rv, 32'h80000007);
    rd(12'h343, rv); check_eq("trap_mtval", rv, 32'hDEAD);
    trap_cause = 32'h2;
    #1;
    check_eq("trap_target_exc", trap_target_o, 32'h100);

    // mret
    @(negedge clk);
    mret_valid = 1'b1;
    @(posedge clk);
    #1;
    mret_valid = 1'b0;
    rd(12'h300, rv); check_eq("mret_mstatus", rv, 32'h00001888);

    // Trap + mret + unrelated CSR write in one cycle
    @(negedge clk);
    trap_valid = 1'b1; trap_cause = 32'h3; trap_pc = 32'h2000; trap_tval = 32'h0;
    mret_valid = 1'b1;
    csr_valid = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h55;
    @(posedge clk);
    #1;
    trap_valid = 1'b0; mret_valid = 1'b0; csr_valid = 1'b0; csr_op = 2'b00;
    rd(12'h300, rv); check_eq("prio_mstatus", rv, 32'h00001880);
    rd(12'h340, rv); check_eq("prio_mscratch", rv, 32'h55);
    check_eq("prio_mepc_o", mepc_o, 32'h2000);
    // mret beats a write to mstatus
    mret_valid = 1'b1;
    csr_wr(2'b01, 12'h300, 32'h0, ill);
    mret_valid = 1'b0;
    rd(12'h300, rv); check_eq("mret_over_wr", rv, 32'h00001888);

    // Interrupts through the synchroniser
    csr_wr(2'b01, 12'h304, 32'h880, ill);
    @(negedge clk);
    irq_mtip = 1'b1;
    irq_meip = 1'b1;
    #1;
    check_eq("irq_req_0clk", {31'd0, irq_req_o}, 32'h0);
    @(posedge clk);
    #1;
    check_eq("irq_req_1clk", {31'd0, irq_req_o}, 32'h0);
    @(posedge clk);
    #1;
    check_eq("irq_req_2clk", {31'd0, irq_req_o}, 32'h1);
    check_eq("irq_cause_mei", irq_cause_o, 32'h8000000B);
    peek(12'h344, rv, ill); check_eq("mip_both", rv, 32'h00000880);
    csr_wr(2'b01, 12'h300, 32'h0, ill);
    check_eq("irq_req_mie0", {31'd0, irq_req_o}, 32'h0);
    check_eq("irq_cause_none", irq_cause_o, 32'h0);
    csr_wr(2'b01, 12'h300, 32'h8, ill);
    check_eq("irq_req_mie1", {31'd0, irq_req_o}, 32'h1);
    @(negedge clk);
    irq_meip = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("irq_cause_mti", irq_cause_o, 32'h80000007);
    @(negedge clk);
    irq_mtip = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_eq("irq_req_drop", {31'd0, irq_req_o}, 32'h0);

    // mcycle carry into the high half
    csr_wr(2'b01, 12'hB80, 32'h0, ill);
    csr_wr(2'b01, 12'hB00, 32'hFFFFFFFF, ill);
    peek(12'hB00, rv, ill); check_eq("mcycle_pre", rv, 32'hFFFFFFFF);
    peek(12'hB80, rv, ill); check_eq("mcycleh_pre", rv, 32'h0);
    @(posedge clk);
    #1;
    peek(12'hB00, rv, ill); check_eq("mcycle_wrap", rv, 32'h0);
    peek(12'hB80, rv, ill); check_eq("mcycleh_carry", rv, 32'h1);

    // minstret: write overrides retire, then increments, then 64-bit wrap
    retire = 1'b1;
    csr_wr(2'b01, 12'hB02, 32'h5, ill);
    retire = 1'b0;
    rd(12'hB02, rv); check_eq("minstret_wr", rv, 32'h5);
    @(negedge clk);
    retire = 1'b1;
    @(posedge clk);
    #1;
    retire = 1'b0;
    rd(12'hB02, rv); check_eq("minstret_inc", rv, 32'h6);
    csr_wr(2'b01, 12'hB82, 32'hFFFFFFFF, ill);
    csr_wr(2'b01, 12'hB02, 32'hFFFFFFFF, ill);
    @(negedge clk);
    retire = 1'b1;
    @(posedge clk);
    #1;
    retire = 1'b0;
    rd(12'hB02, rv); check_eq("minstret_wrap_lo", rv, 32'h0);
    rd(12'hB82, rv); check_eq("minstret_wrap_hi", rv, 32'h0);

    // Asynchronous reset mid-operation, no clock edge
    @(negedge clk);
    rst = 1'b0;
    peek(12'h340, rv, ill); check_eq("arst_mscratch", rv, 32'h0);
    peek(12'h305, rv, ill); check_eq("arst_mtvec", rv, 32'h80000000);
    check_eq("arst_mepc_o", mepc_o, 32'h0);
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_csr_file.md
# ysyx_csr_file

Parametrised machine-mode CSR file for the EXU. It holds trap state, interrupt enable/pending, scratch and 64-bit cycle/instret counters. It performs RISC-V Zicsr read-modify-write, trap entry and `mret` atomically, and presents the trap target, `mepc` and the interrupt request to the fetch/redirect logic.

## Interface

**Parameters** (name, default, meaning)

- `XLEN`, 32: register width; 32 or 64.
- `MTVEC_RST`, 0: reset value of `mtvec`.
- `VENDOR_ID`, 32'h79737978: `mvendorid` value.
- `ARCH_ID`, 32'h015fde77: `marchid` value.
- `HAS_CNT`, 1: 1 implements `mcycle`/`minstret`. 0 makes them read 0, and writes to them are ignored (still legal).

**Ports** (name, direction, width, meaning)

- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `csr_valid` in 1: CSR instruction commits this cycle.
- `csr_op` in 2: 01 RW, 10 RS, 11 RC, 00 read-only.
- `csr_addr` in 12: CSR address.
- `csr_wdata` in XLEN: rs1 value or zimm.
- `csr_rdata` out XLEN: combinational read of `csr_addr`; returns the old value.
- `csr_illegal` out 1: combinational; the access is illegal.
- `trap_valid` in 1: exception or interrupt taken this cycle.
- `trap_cause` in XLEN: `mcause` value; MSB set means interrupt.
- `trap_pc` in XLEN: faulting PC.
- `trap_tval` in XLEN: `mtval` value.
- `mret_valid` in 1: `mret` commits.
- `retire` in 1: one instruction retired.
- `irq_mtip` in 1: timer interrupt line, asynchronous.
- `irq_meip` in 1: external interrupt line, asynchronous.
- `trap_target_o` out XLEN: trap vector.
- `mepc_o` out XLEN: current `mepc`.
- `irq_req_o` out 1: interrupt should be taken.
- `irq_cause_o` out XLEN: cause for `irq_req_o`.

## Operation

**Implemented CSRs**

- `mstatus` 0x300: MIE[3] and MPIE[7] are writable. MPP[12:11] reads 2'b11. All other bits read 0.
- `misa` 0x301: read-only.
- `mie` 0x304: MTIE[7] and MEIE[11] are writable.
- `mtvec` 0x305: BASE[XLEN-1:2] and MODE[0] are writable. MODE[1] reads 0.
- `mscratch` 0x340.
- `mepc` 0x341: bits [1:0] are forced to 0 on write.
- `mcause` 0x342.
- `mtval` 0x343.
- `mip` 0x344: read-only. MTIP[7] and MEIP[11] come from the synchronised inputs.
- `mcycle` 0xB00, `minstret` 0xB02.
- `mcycleh` 0xB80 and `minstreth` 0xB82: exist only when XLEN=32.
- `mvendorid` 0xF11, `marchid` 0xF12, `mimpid` 0xF13 (reads 0), `mhartid` 0xF14 (reads 0).

**Write value**

- RW: `wdata`.
- RS: `old | wdata`.
- RC: `old & ~wdata`.
- A write happens only when `csr_valid`, `!csr_illegal`, and `csr_op` is nonzero.
- RS or RC with `csr_wdata == 0` performs no write.

**Illegal accesses** (`csr_illegal = 1`)

- An unimplemented address, including the `*h` addresses when XLEN=64.
- A write to 0xF11–0xF14, `misa` or `mip`.
- An illegal access changes no state.

**Trap entry** (`trap_valid`)

- `mepc` ← `trap_pc & ~3`.
- `mcause` ← `trap_cause`.
- `mtval` ← `trap_tval`.
- MPIE ← MIE, then MIE ← 0.

**`mret`**

- MIE ← MPIE, then MPIE ← 1.

**Same-cycle priority**

- Trap beats `mret`, and `mret` beats a CSR write for the fields both touch.
- A CSR write to fields the trap does not touch still lands.

**Trap target**

- Equals BASE<<2.
- If MODE=1 and `trap_cause` MSB=1, it is BASE<<2 + 4·cause[XLEN-2:0], truncated to XLEN.

**Interrupts**

- `irq_mtip` and `irq_meip` pass through a 2-flop synchroniser into `mip`.
- `irq_req_o = MIE & |(mip & mie)`.
- `irq_cause_o`: MEI (MSB | 11) has priority over MTI (MSB | 7). It is 0 when there is no request.

**Counters**

- 64-bit. `mcycle` increments every cycle; `minstret` increments on `retire`.
- Both wrap from 2^64−1 to 0.
- A CSR write to any half of a counter overrides that cycle's increment. The written half takes the write value, and the other half holds.

## Timing

- All state updates on `posedge clk`. Reads and `illegal` are combinational with zero latency.
- Reset (asynchronous on `rst` low):
  - `mstatus` MIE = MPIE = 0.
  - `mtvec` = `MTVEC_RST`.
  - All other CSRs and the counters = 0.
  - Synchronisers = 0.
  - `irq_req_o` = 0, `irq_cause_o` = 0.
  - `trap_target_o` = `MTVEC_RST` with bits [1:0] masked.
  - `mepc_o` = 0.
- Reset asserted mid-operation clears state immediately, with no clock needed.
- An interrupt edge on `irq_*` reaches `mip` after 2 clocks. `irq_req_o` follows in the same cycle as `mip`.
- A CSR write to MIE or `mie` is visible on `irq_req_o` the next cycle.
- A read of a counter returns the pre-increment value of that cycle.

## Test plan

- **Reset:** release reset with `MTVEC_RST` = 0x80000000. Read 0x305 → 0x80000000. Read 0x300 → 0x1800. Read 0xF11 → 0x79737978.
- **RMW:** RW 0x340 ← 0xA5A5A5A5, then RS 0x0F, then RC 0xA0 → read 0xA5A5A50F. RS with wdata 0 on 0xF11 → not illegal, no change.
- **Illegal:** RW 0xF12 ← 1 → `csr_illegal`=1, value unchanged. Read 0x7C0 → `csr_illegal`=1.
- **Trap and `mret`:**
  - With MIE=1, trap cause 0x80000007 at PC 0x1002 and `mtvec` 0x100|1.
  - After trap: `mepc`=0x1000, `trap_target_o`=0x11C, MIE=0, MPIE=1.
  - `mret` → MIE=1.
- **Interrupt:** MIE=1, `mie`=0x880, raise both `irq_*` → `irq_req_o` high on the 2nd clock with cause 0x8000000B. Clear MIE → `irq_req_o` low the next cycle.
- **Counters:**
  - Write `mcycle` ← 0xFFFFFFFF with `mcycleh` = 0 → next cycle `mcycleh`=1, `mcycle`=0.
  - Assert `retire` with a simultaneous write to 0xB02 ← 5 → `minstret`=5.
